// File: rtl/binary_morph_nxn.sv
// binary_morph_nxn: streaming KSIZE x KSIZE binary erosion/dilation with line buffers.
// Optional foreground pixel counter enabled by defining MORPH_CNT_EN.
module binary_morph_nxn #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int KSIZE      = 3,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_frame_clken,
  input  logic per_img_Bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_Bit
`ifdef MORPH_CNT_EN
  ,
  output logic [CNT_W-1:0] post_fg_count
`endif
);

  localparam int R  = (KSIZE - 1) / 2;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic acc, vs_rise, hr_fall, pad;
  logic vs_q, hr_q, mode_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [IMG_WIDTH-1:0] lb_q [KSIZE-1];
  logic [KSIZE-2:0]     win_q [KSIZE];
  logic [KSIZE-1:0]     vcol;
  logic [KSIZE-1:0]     red_d, red_q;
  logic                 val_d, val_q, md1_q;
  logic                 bit_q;
  logic                 vs_d1, hr_d1, ce_d1;
  logic                 vs_d2, hr_d2, ce_d2;

  assign acc     = per_frame_clken & per_frame_href;
  assign vs_rise = per_frame_vsync & ~vs_q;
  assign hr_fall = hr_q & ~per_frame_href;
  assign pad     = ~mode_q;

  // Next column/row position; both saturate on over-run
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc && col_q != CW'(IMG_WIDTH - 1))
      col_d = col_q + 1'b1;
    if (hr_fall)
      col_d = '0;
    if (hr_fall && row_q != RW'(IMG_HEIGHT - 1))
      row_d = row_q + 1'b1;
    if (vs_rise)
      row_d = '0;
  end

  // Sync edge history, per-frame mode latch and position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      hr_q   <= 1'b0;
      mode_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      vs_q  <= per_frame_vsync;
      hr_q  <= per_frame_href;
      if (vs_rise)
        mode_q <= mode;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Newest window column; rows above the image (or stale frames) read as pad
  always_comb begin
    vcol    = '0;
    vcol[0] = per_img_Bit;
    for (int k = 1; k < KSIZE; k++)
      vcol[k] = (int'(row_q) < k) ? pad : lb_q[k-1][col_q];
  end

  // Row-wise reduction over the full window; taps left of col 0 are skipped
  always_comb begin
    red_d = '0;
    for (int k = 0; k < KSIZE; k++) begin
      red_d[k] = vcol[k];
      for (int j = 1; j < KSIZE; j++)
        if (int'(col_q) >= j)
          red_d[k] = mode_q ? (red_d[k] | win_q[k][j-1])
                            : (red_d[k] & win_q[k][j-1]);
    end
  end

  assign val_d = acc & (int'(row_q) >= R) & (int'(col_q) >= R);

  // Line buffers and window shift on each accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KSIZE - 1; k++)
        lb_q[k] <= '0;
      for (int k = 0; k < KSIZE; k++)
        win_q[k] <= '0;
    end else if (acc) begin
      lb_q[0][col_q] <= per_img_Bit;
      for (int k = 1; k < KSIZE - 1; k++)
        lb_q[k][col_q] <= lb_q[k-1][col_q];
      for (int k = 0; k < KSIZE; k++)
        win_q[k] <= {win_q[k][KSIZE-3:0], vcol[k]};
    end
  end

  // Two-stage reduction pipeline with matching sync delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q <= '0;
      val_q <= 1'b0;
      md1_q <= 1'b0;
      bit_q <= 1'b0;
      vs_d1 <= 1'b0;
      hr_d1 <= 1'b0;
      ce_d1 <= 1'b0;
      vs_d2 <= 1'b0;
      hr_d2 <= 1'b0;
      ce_d2 <= 1'b0;
    end else begin
      red_q <= red_d;
      val_q <= val_d;
      md1_q <= mode_q;
      bit_q <= val_q & (md1_q ? |red_q : &red_q);
      vs_d1 <= per_frame_vsync;
      hr_d1 <= per_frame_href;
      ce_d1 <= per_frame_clken;
      vs_d2 <= vs_d1;
      hr_d2 <= hr_d1;
      ce_d2 <= ce_d1;
    end
  end

  assign post_frame_vsync = vs_d2;
  assign post_frame_href  = hr_d2;
  assign post_frame_clken = ce_d2;
  assign post_img_Bit     = bit_q;

`ifdef MORPH_CNT_EN
  logic [CNT_W-1:0] cnt_q, fg_q;
  logic             pvs_q;

  // Count foreground outputs; publish and clear at end of output frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      fg_q  <= '0;
      pvs_q <= 1'b0;
    end else begin
      pvs_q <= vs_d2;
      if (pvs_q && !vs_d2) begin
        fg_q  <= cnt_q;
        cnt_q <= '0;
      end else if (bit_q && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign post_fg_count = fg_q;
`endif

endmodule

// File: tb/tb_binary_morph_nxn.sv
// tb_binary_morph_nxn: random and directed frames against a window model.
// Runs KSIZE=3 and KSIZE=5 instances side by side on the same stream.
module tb_binary_morph_nxn;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CW = 20;

  logic clk = 0;
  logic rst_n = 0;
  logic mode = 0;
  logic vs = 0, hr = 0, ce = 0, pix = 0;
  logic o3_vs, o3_hr, o3_ce, o3_bit;
  logic o5_vs, o5_hr, o5_ce, o5_bit;
`ifdef MORPH_CNT_EN
  logic [CW-1:0] fg3, fg5;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int stray = 0;

  logic img [H][W];
  logic q3[$], q5[$];
  int   c3[$], inq[$];

  always #5 clk = ~clk;

  binary_morph_nxn #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KSIZE(3), .CNT_W(CW)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .per_frame_vsync(vs), .per_frame_href(hr),
    .per_frame_clken(ce), .per_img_Bit(pix),
    .post_frame_vsync(o3_vs), .post_frame_href(o3_hr),
    .post_frame_clken(o3_ce), .post_img_Bit(o3_bit)
`ifdef MORPH_CNT_EN
    , .post_fg_count(fg3)
`endif
  );

  binary_morph_nxn #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KSIZE(5), .CNT_W(CW)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .per_frame_vsync(vs), .per_frame_href(hr),
    .per_frame_clken(ce), .per_img_Bit(pix),
    .post_frame_vsync(o5_vs), .post_frame_href(o5_hr),
    .post_frame_clken(o5_ce), .post_img_Bit(o5_bit)
`ifdef MORPH_CNT_EN
    , .post_fg_count(fg5)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o3_ce && o3_hr) begin
      q3.push_back(o3_bit);
      c3.push_back(cyc);
    end else if (o3_bit) begin
      stray++;
    end
    if (o5_ce && o5_hr)
      q5.push_back(o5_bit);
    else if (o5_bit)
      stray++;
  end

  // Reference: window of rows r-k+1..r, cols c-k+1..c, neutral pad outside.
  function automatic logic ref_px(int k, int md, int r, int c);
    int    rr;
    logic  a, t;
    rr = (k - 1) / 2;
    if (r < rr || c < rr) return 1'b0;
    a = (md == 0);
    for (int dr = 0; dr < k; dr++)
      for (int dc = 0; dc < k; dc++) begin
        if (r - dr < 0 || c - dc < 0) t = (md == 0);
        else t = img[r-dr][c-dc];
        a = (md != 0) ? (a | t) : (a & t);
      end
    return a;
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (kind == 0) ? 1'b0 :
                    (kind == 1) ? 1'b1 : 1'($urandom_range(1));
  endtask

  task automatic run_frame(input int m0, input int m1, input int duty);
    int c;
    q3.delete(); q5.delete(); c3.delete(); inq.delete();
    @(negedge clk);
    mode = 1'(m0);
    vs = 1;
    repeat (3) @(negedge clk);
    for (int r = 0; r < H; r++) begin
      if (r == H / 2) mode = 1'(m1);
      hr = 1;
      c = 0;
      while (c < W) begin
        ce = ($urandom_range(99) < duty);
        pix = ce ? img[r][c] : 1'($urandom_range(1));
        if (ce) begin
          inq.push_back(cyc);
          c++;
        end
        @(negedge clk);
      end
      ce = 0; hr = 0; pix = 0;
      repeat (3) @(negedge clk);
    end
    vs = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({o3_vs, o3_hr, o3_ce, o3_bit} !== 4'b0)
      $display("FAIL reset_out3 got %b want 0000", {o3_vs, o3_hr, o3_ce, o3_bit});
    else n_pass++;
    n_chk++;
    if ({o5_vs, o5_hr, o5_ce, o5_bit} !== 4'b0)
      $display("FAIL reset_out5 got %b want 0000", {o5_vs, o5_hr, o5_ce, o5_bit});
    else n_pass++;
`ifdef MORPH_CNT_EN
    n_chk++;
    if (fg3 !== '0) $display("FAIL reset_fg got %0d want 0", fg3);
    else n_pass++;
`endif
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_erode_ones;
    int ones3 = 0, ones5 = 0;
    logic e3, e5;
    fill(1);
    run_frame(0, 0, 100);
    n_chk++;
    if (q3.size() != W * H) $display("FAIL ones_cnt got %0d want %0d", q3.size(), W * H);
    else n_pass++;
    for (int i = 0; i < W * H; i++) begin
      e3 = ref_px(3, 0, i / W, i % W);
      e5 = ref_px(5, 0, i / W, i % W);
      ones3 += int'(e3);
      ones5 += int'(e5);
      n_chk++;
      if (q3[i] !== e3) $display("FAIL ones_k3 px%0d got %b want %b", i, q3[i], e3);
      else n_pass++;
      n_chk++;
      if (q5[i] !== e5) $display("FAIL ones_k5 px%0d got %b want %b", i, q5[i], e5);
      else n_pass++;
    end
`ifdef MORPH_CNT_EN
    n_chk++;
    if (fg3 !== CW'(ones3)) $display("FAIL fg_k3 got %0d want %0d", fg3, ones3);
    else n_pass++;
    n_chk++;
    if (fg5 !== CW'(ones5)) $display("FAIL fg_k5 got %0d want %0d", fg5, ones5);
    else n_pass++;
`else
    if (ones3 + ones5 < 0) $display("model error");
`endif
  endtask

  task automatic test_dilate_single;
    logic e3;
    fill(0);
    img[4][4] = 1;
    run_frame(1, 1, 100);
    n_chk++;
    if (q3.size() != W * H) $display("FAIL dil_cnt got %0d want %0d", q3.size(), W * H);
    else n_pass++;
    for (int i = 0; i < W * H; i++) begin
      e3 = ref_px(3, 1, i / W, i % W);
      n_chk++;
      if (q3[i] !== e3) $display("FAIL dil_k3 px%0d got %b want %b", i, q3[i], e3);
      else n_pass++;
      n_chk++;
      if (c3[i] !== inq[i] + 2)
        $display("FAIL dil_lat px%0d got %0d want %0d", i, c3[i] - inq[i], 2);
      else n_pass++;
    end
  endtask

  task automatic test_corner_zero;
    logic e3, e5;
    fill(1);
    img[0][0] = 0;
    run_frame(0, 0, 100);
    for (int i = 0; i < W * H; i++) begin
      e3 = ref_px(3, 0, i / W, i % W);
      e5 = ref_px(5, 0, i / W, i % W);
      n_chk++;
      if (q3[i] !== e3) $display("FAIL corner_k3 px%0d got %b want %b", i, q3[i], e3);
      else n_pass++;
      n_chk++;
      if (q5[i] !== e5) $display("FAIL corner_k5 px%0d got %b want %b", i, q5[i], e5);
      else n_pass++;
    end
  endtask

  task automatic test_mode_switch;
    logic e3;
    fill(2);
    run_frame(0, 1, 100);
    for (int i = 0; i < W * H; i++) begin
      e3 = ref_px(3, 0, i / W, i % W);
      n_chk++;
      if (q3[i] !== e3) $display("FAIL msw_a px%0d got %b want %b", i, q3[i], e3);
      else n_pass++;
    end
    fill(2);
    run_frame(1, 1, 100);
    for (int i = 0; i < W * H; i++) begin
      e3 = ref_px(3, 1, i / W, i % W);
      n_chk++;
      if (q3[i] !== e3) $display("FAIL msw_b px%0d got %b want %b", i, q3[i], e3);
      else n_pass++;
    end
  endtask

  task automatic test_random_k5;
    int   md;
    logic e3, e5;
    for (int f = 0; f < 4; f++) begin
      fill(2);
      md = int'($urandom_range(1));
      run_frame(md, md, 30);
      n_chk++;
      if (q5.size() != inq.size())
        $display("FAIL rnd_cnt f%0d got %0d want %0d", f, q5.size(), inq.size());
      else n_pass++;
      for (int i = 0; i < W * H; i++) begin
        e3 = ref_px(3, md, i / W, i % W);
        e5 = ref_px(5, md, i / W, i % W);
        n_chk++;
        if (q5[i] !== e5) $display("FAIL rnd_k5 f%0d px%0d got %b want %b", f, i, q5[i], e5);
        else n_pass++;
        n_chk++;
        if (q3[i] !== e3) $display("FAIL rnd_k3 f%0d px%0d got %b want %b", f, i, q3[i], e3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic e3, e5;
    @(negedge clk);
    vs = 1;
    repeat (2) @(negedge clk);
    hr = 1;
    for (int i = 0; i < 12; i++) begin
      ce = 1;
      pix = 1'($urandom_range(1));
      @(negedge clk);
    end
    rst_n = 0;
    #1;
    n_chk++;
    if ({o3_vs, o3_hr, o3_ce, o3_bit} !== 4'b0)
      $display("FAIL midrst_out3 got %b want 0000", {o3_vs, o3_hr, o3_ce, o3_bit});
    else n_pass++;
    n_chk++;
    if ({o5_vs, o5_hr, o5_ce, o5_bit} !== 4'b0)
      $display("FAIL midrst_out5 got %b want 0000", {o5_vs, o5_hr, o5_ce, o5_bit});
    else n_pass++;
`ifdef MORPH_CNT_EN
    n_chk++;
    if (fg3 !== '0 || fg5 !== '0)
      $display("FAIL midrst_fg got %0d/%0d want 0/0", fg3, fg5);
    else n_pass++;
`endif
    ce = 0; hr = 0; vs = 0; pix = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    fill(2);
    run_frame(1, 1, 60);
    for (int i = 0; i < W * H; i++) begin
      e3 = ref_px(3, 1, i / W, i % W);
      e5 = ref_px(5, 1, i / W, i % W);
      n_chk++;
      if (q3[i] !== e3) $display("FAIL post_rst_k3 px%0d got %b want %b", i, q3[i], e3);
      else n_pass++;
      n_chk++;
      if (q5[i] !== e5) $display("FAIL post_rst_k5 px%0d got %b want %b", i, q5[i], e5);
      else n_pass++;
    end
    n_chk++;
    if (stray != 0) $display("FAIL stray_bits got %0d want 0", stray);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_erode_ones();
    test_dilate_single();
    test_corner_zero();
    test_mode_switch();
    test_random_k5();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
